// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//
// Generates the phase / p0 / exec timing that the combinational control unit
// decodes for the 16-bit multi-phase processor. A front-panel start/stop button
// starts execution; pressing it while running stops after the current
// instruction. A halt request (stop_flag) from the control unit during the
// final phase stops execution and sets the sticky halted flag.
//
// Optional feature macro: SINGLE_STEP_EN
//   When defined, adds the step_btn input. A step press in IDLE runs exactly one
//   instruction and returns to IDLE.
//
// Parameters
//   PHASES       execution phases per instruction (1..PHASES), legal 2..7
//   SYNC_STAGES  flip-flop stages per button synchronizer, legal 2..3
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   exec_btn     in   raw start/stop button (asynchronous)
//   step_btn     in   raw single-step button (SINGLE_STEP_EN only)
//   stop_flag    in   HLT request, honoured only in phase PHASES
//   phase        out  current phase, 0 = idle
//   p0           out  high when phase == 0
//   exec         out  high while an instruction is executing
//   instr_done   out  high during the cycle phase == PHASES
//   halted       out  sticky, set when execution stopped due to stop_flag
//   instr_count  out  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// phase_sequencer_btn
//
// Button conditioner: SYNC_STAGES synchronizer followed by a registered
// rising-edge detector. The detector only arms once the synchronized level has
// been observed low after reset, so a button held through reset never yields a
// request when reset is released.
//
// Ports
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   btn   in   raw asynchronous button level
//   req   out  one-cycle request, SYNC_STAGES+1 edges after a raw rise
// -----------------------------------------------------------------------------
module phase_sequencer_btn #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic req
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES-1:0] fill_r;
  logic                   prev_r;
  logic                   armed_r;
  logic                   req_r;
  logic                   sync_last_s;
  logic                   fill_done_s;

  assign sync_last_s = sync_r[SYNC_STAGES-1];
  // fill_r tracks when the synchronizer holds real button samples again
  assign fill_done_s = fill_r[SYNC_STAGES-1];

  // Synchronizer, arming flag and registered rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r  <= '0;
      fill_r  <= '0;
      prev_r  <= 1'b0;
      armed_r <= 1'b0;
      req_r   <= 1'b0;
    end else begin
      sync_r  <= {sync_r[SYNC_STAGES-2:0], btn};
      fill_r  <= {fill_r[SYNC_STAGES-2:0], 1'b1};
      prev_r  <= sync_last_s;
      armed_r <= armed_r | (fill_done_s & ~sync_last_s);
      req_r   <= armed_r & sync_last_s & ~prev_r;
    end
  end

  assign req = req_r;

endmodule

module phase_sequencer #(
  parameter int PHASES      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec_btn,
`ifdef SINGLE_STEP_EN
  input  logic        step_btn,
`endif
  input  logic        stop_flag,
  output logic [2:0]  phase,
  output logic        p0,
  output logic        exec,
  output logic        instr_done,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  localparam logic [2:0] LAST_PHASE = 3'(PHASES);
  localparam logic [2:0] PRE_LAST   = 3'(PHASES - 1);

  state_t      state_r;
  logic [2:0]  phase_r;
  logic        exec_r;
  logic        instr_done_r;
  logic        halted_r;
  logic [15:0] instr_count_r;
  logic        start_req_s;
  logic        step_req_s;

  phase_sequencer_btn #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_exec_btn (
    .clk (clk),
    .rst (rst),
    .btn (exec_btn),
    .req (start_req_s)
  );

`ifdef SINGLE_STEP_EN
  phase_sequencer_btn #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_step_btn (
    .clk (clk),
    .rst (rst),
    .btn (step_btn),
    .req (step_req_s)
  );
`else
  assign step_req_s = 1'b0;
`endif

  // Sequencer state machine with registered phase, exec, flags and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      phase_r       <= 3'd0;
      exec_r        <= 1'b0;
      instr_done_r  <= 1'b0;
      halted_r      <= 1'b0;
      instr_count_r <= 16'd0;
    end else begin
      instr_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_req_s) begin
            // start has priority over a simultaneous step
            state_r  <= ST_RUN;
            phase_r  <= 3'd1;
            exec_r   <= 1'b1;
            halted_r <= 1'b0;
          end else if (step_req_s) begin
            // a step is a run that is already scheduled to stop
            state_r  <= ST_STOPPING;
            phase_r  <= 3'd1;
            exec_r   <= 1'b1;
            halted_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            phase_r <= 3'd0;
            exec_r  <= 1'b0;
          end
        end
        ST_RUN, ST_STOPPING: begin
          if (phase_r == LAST_PHASE) begin
            // instruction retires here, HLT included
            instr_count_r <= instr_count_r + 16'd1;
            // a button press landing in the last phase means "stop after this
            // instruction", which is now; it never causes a restart
            if (stop_flag || (state_r == ST_STOPPING) || start_req_s) begin
              state_r  <= ST_IDLE;
              phase_r  <= 3'd0;
              exec_r   <= 1'b0;
              halted_r <= stop_flag;
            end else begin
              state_r <= ST_RUN;
              phase_r <= 3'd1;
              exec_r  <= 1'b1;
            end
          end else begin
            phase_r      <= phase_r + 3'd1;
            instr_done_r <= (phase_r == PRE_LAST);
            if ((state_r == ST_RUN) && start_req_s) begin
              state_r <= ST_STOPPING;
            end else begin
              state_r <= state_r;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          phase_r <= 3'd0;
          exec_r  <= 1'b0;
        end
      endcase
    end
  end

  assign phase       = phase_r;
  // pure decode of a registered value, so it cannot glitch between edges
  assign p0          = (phase_r == 3'd0);
  assign exec        = exec_r;
  assign instr_done  = instr_done_r;
  assign halted      = halted_r;
  assign instr_count = instr_count_r;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

  localparam int PHASES = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exec_btn = 1'b0;
  logic        stop_flag = 1'b0;
`ifdef SINGLE_STEP_EN
  logic        step_btn = 1'b0;
`endif
  logic [2:0]  phase;
  logic        p0;
  logic        exec;
  logic        instr_done;
  logic        halted;
  logic [15:0] instr_count;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  phase_sequencer #(
    .PHASES      (PHASES),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exec_btn    (exec_btn),
`ifdef SINGLE_STEP_EN
    .step_btn    (step_btn),
`endif
    .stop_flag   (stop_flag),
    .phase       (phase),
    .p0          (p0),
    .exec        (exec),
    .instr_done  (instr_done),
    .halted      (halted),
    .instr_count (instr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bounded wait (at negedges) until phase reaches p; always one comparison.
  task automatic wait_phase(input logic [2:0] p, input string name);
    int k;
    k = 0;
    while (phase !== p && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(name, {29'd0, phase}, {29'd0, p});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every instr_done pulse retires one expected instruction.
  always @(negedge clk) begin
    if (instr_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got instr_done=1 count=%0h expected no pulse", instr_count);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("done_count", {16'd0, instr_count}, {16'd0, mon_exp});
        chk("done_phase", {29'd0, phase}, PHASES);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_phase", {29'd0, phase}, 32'd0);
    chk("rst_p0", {31'd0, p0}, 32'd1);
    chk("rst_exec", {31'd0, exec}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_count", {16'd0, instr_count}, 32'd0);
    chk("rst_done", {31'd0, instr_done}, 32'd0);

    // ---------------- start / run ----------------
    idle(5);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2);
    exec_btn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pre_start_phase", {29'd0, phase}, 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      chk("run_phase", {29'd0, phase}, (i % 5) + 1);
      chk("run_exec", {31'd0, exec}, 32'd1);
      @(negedge clk);
    end
    chk("run_count3", {16'd0, instr_count}, 32'd3);
    chk("run_p0", {31'd0, p0}, 32'd0);
    exec_btn = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---------------- HLT ----------------
    idle(5);
    exp_q.push_back(16'd0);
    exp_q.push_back(16'd1);
    exec_btn = 1'b1;
    wait_phase(3'd1, "hlt_start");
    exec_btn = 1'b0;
    wait_phase(3'd3, "hlt_ph3");
    stop_flag = 1'b1;
    @(negedge clk);
    stop_flag = 1'b0;
    chk("hlt_ignored_phase", {29'd0, phase}, 32'd4);
    chk("hlt_ignored_exec", {31'd0, exec}, 32'd1);
    wait_phase(3'd5, "hlt_i1_ph5");
    wait_phase(3'd1, "hlt_i2_ph1");
    wait_phase(3'd5, "hlt_i2_ph5");
    stop_flag = 1'b1;
    @(negedge clk);
    stop_flag = 1'b0;
    chk("hlt_phase", {29'd0, phase}, 32'd0);
    chk("hlt_p0", {31'd0, p0}, 32'd1);
    chk("hlt_exec", {31'd0, exec}, 32'd0);
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_count", {16'd0, instr_count}, 32'd2);
    idle(6);
    chk("hlt_stays_idle", {29'd0, phase}, 32'd0);

    // ---------------- button stop (count carries over, halted cleared) ----------------
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd3);
    exec_btn = 1'b1;
    wait_phase(3'd1, "bstop_start");
    exec_btn = 1'b0;
    chk("bstop_halted_clr", {31'd0, halted}, 32'd0);
    wait_phase(3'd4, "bstop_i1_ph4");
    exec_btn = 1'b1;
    @(negedge clk);
    exec_btn = 1'b0;
    @(negedge clk);
    chk("bstop_i2_ph1", {29'd0, phase}, 32'd1);
    exec_btn = 1'b1;
    @(negedge clk);
    exec_btn = 1'b0;
    chk("bstop_i2_ph2", {29'd0, phase}, 32'd2);
    for (int p = 3; p <= 5; p++) begin
      @(negedge clk);
      chk("bstop_i2_phase", {29'd0, phase}, p);
    end
    @(negedge clk);
    chk("bstop_phase", {29'd0, phase}, 32'd0);
    chk("bstop_exec", {31'd0, exec}, 32'd0);
    chk("bstop_halted", {31'd0, halted}, 32'd0);
    chk("bstop_count", {16'd0, instr_count}, 32'd4);
    idle(8);
    chk("bstop_no_restart", {29'd0, phase}, 32'd0);

    // ---------------- reset mid-instruction, button held through reset ----------------
    exec_btn = 1'b1;
    wait_phase(3'd1, "mrst_start");
    wait_phase(3'd3, "mrst_ph3");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_phase", {29'd0, phase}, 32'd0);
    chk("mrst_count", {16'd0, instr_count}, 32'd0);
    chk("mrst_exec", {31'd0, exec}, 32'd0);
    chk("mrst_done", {31'd0, instr_done}, 32'd0);
    idle(10);
    chk("held_btn_no_start", {29'd0, phase}, 32'd0);
    exec_btn = 1'b0;

    // ---------------- counter wrap ----------------
    idle(5);
    force dut.instr_count_r = 16'hFFFF;
    @(negedge clk);
    release dut.instr_count_r;
    @(negedge clk);
    chk("wrap_preset", {16'd0, instr_count}, 32'h0000FFFF);
    exp_q.push_back(16'hFFFF);
    exec_btn = 1'b1;
    wait_phase(3'd1, "wrap_start");
    exec_btn = 1'b0;
    wait_phase(3'd5, "wrap_ph5");
    stop_flag = 1'b1;
    @(negedge clk);
    stop_flag = 1'b0;
    chk("wrap_count", {16'd0, instr_count}, 32'd0);
    chk("wrap_halted", {31'd0, halted}, 32'd1);
    chk("wrap_phase", {29'd0, phase}, 32'd0);

`ifdef SINGLE_STEP_EN
    // ---------------- single step ----------------
    idle(5);
    exp_q.push_back(16'd0);
    step_btn = 1'b1;
    @(negedge clk);
    step_btn = 1'b0;
    wait_phase(3'd1, "step_start");
    chk("step_exec", {31'd0, exec}, 32'd1);
    for (int p = 2; p <= 5; p++) begin
      @(negedge clk);
      chk("step_phase", {29'd0, phase}, p);
    end
    @(negedge clk);
    chk("step_end_phase", {29'd0, phase}, 32'd0);
    chk("step_count", {16'd0, instr_count}, 32'd1);
    chk("step_halted", {31'd0, halted}, 32'd0);
    idle(8);
    chk("step_stays_idle", {29'd0, phase}, 32'd0);

    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2);
    exec_btn = 1'b1;
    wait_phase(3'd1, "sr_start");
    exec_btn = 1'b0;
    wait_phase(3'd2, "sr_ph2");
    step_btn = 1'b1;
    @(negedge clk);
    step_btn = 1'b0;
    wait_phase(3'd5, "sr_i1_ph5");
    wait_phase(3'd1, "sr_i2_ph1");
    wait_phase(3'd5, "sr_i2_ph5");
    stop_flag = 1'b1;
    @(negedge clk);
    stop_flag = 1'b0;
    chk("sr_count", {16'd0, instr_count}, 32'd3);
    chk("sr_phase", {29'd0, phase}, 32'd0);
    idle(8);
    chk("sr_stays_idle", {29'd0, phase}, 32'd0);
`endif

    idle(2);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Phase sequencer for the 16-bit multi-phase processor. It generates the `phase`, `p0` and `exec` signals that the combinational control unit decodes, and it consumes that unit's `stop_flag` (HLT) to end execution. It sits between the board start/stop button and the control unit. It also provides an instruction-completion pulse and a retired-instruction counter for the debug display.

## Interface
- `PHASES`, default 5: number of execution phases per instruction, numbered 1..PHASES; phase 0 is idle. Legal range 2..7.
- `SYNC_STAGES`, default 2: flip-flop stages in each button synchronizer. Legal range 2..3.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `exec_btn`  in  1  raw start/stop button, asynchronous, active-high
- `stop_flag`  in  1  halt request from the control unit, valid during the final phase
- `phase`  out  3  current phase, 0 = idle, 1..PHASES = executing
- `p0`  out  1  high exactly when `phase` == 0
- `exec`  out  1  high while the processor is running
- `instr_done`  out  1  one-cycle pulse on the last cycle of phase PHASES
- `halted`  out  1  sticky; set when a stop was caused by `stop_flag`
- `instr_count`  out  16  retired-instruction counter

## Operation
- **Button conditioning.**
  - `exec_btn` passes through a `SYNC_STAGES` flip-flop synchronizer.
  - A rising-edge detector on the synchronized signal produces a one-cycle `start_req`.
- **State machine.** States are IDLE, RUN and STOPPING.
- **IDLE:**
  - `phase`=0, `p0`=1, `exec`=0.
  - On `start_req`, go to RUN with `phase`=1 and clear `halted`.
- **RUN:**
  - `phase` increments by 1 each cycle.
  - At `phase`==PHASES, `instr_done`=1 and `instr_count` increments.
  - The next phase is 1, unless a stop condition applies, in which case the next state is IDLE with `phase`=0.
  - A stop condition is either `stop_flag`=1 sampled at `phase`==PHASES, or STOPPING being active.
- **STOPPING:**
  - Entered from RUN on `start_req` at any phase. A button press while running requests a stop after the current instruction.
  - Phases continue normally. At the end of phase PHASES, `instr_done` pulses, the counter increments, and the next state is IDLE.
  - `halted` stays 0 unless `stop_flag` is also 1 at that phase.
- **Flags and counter.**
  - `stop_flag` is ignored in every phase except PHASES.
  - `halted` is set when a stop occurs with `stop_flag`=1.
  - `instr_count` wraps from 0xFFFF to 0x0000. It is not cleared on start, only on `rst`.
- **Simultaneous events.**
  - `start_req` and `stop_flag`=1 at `phase`==PHASES: stop once, go to IDLE, set `halted`, and discard the request. No restart occurs.
  - `start_req` while in STOPPING: ignored.
  - An HLT instruction counts as retired.
- **Reset.** `rst` at any time, including mid-instruction, takes effect at the next edge:
  - `phase`=0, `p0`=1, `exec`=0, `instr_done`=0, `halted`=0, `instr_count`=0, state IDLE.
  - The synchronizer and edge-detector registers are cleared.
  - A button held high through reset does not produce a `start_req` after reset.

## Timing
- All outputs are registered. Exception: `p0` is decoded from the registered `phase`, with no glitch-sensitive logic.
- Latency from a raw `exec_btn` rise to `start_req` is `SYNC_STAGES`+1 clock edges. `phase`=1 appears on the edge after `start_req`.
- Each instruction takes exactly PHASES cycles. There are no idle cycles between back-to-back instructions.
- `phase` returns to 0 on the edge immediately after the last cycle of phase PHASES.
- `exec` falls on that same edge.
- `instr_done` is high only during the cycle where `phase`==PHASES.

## Configuration
- **SINGLE_STEP_EN**
  - **Defined:** adds input port `step_btn` (1 bit). It uses its own `SYNC_STAGES` synchronizer and edge detector, producing `step_req`.
  - In IDLE, `step_req` runs exactly one instruction (phases 1..PHASES), then returns to IDLE. `exec` is 1 during those phases. `halted` is updated as for a normal stop.
  - `step_req` in RUN or STOPPING is ignored.
  - `start_req` and `step_req` in the same IDLE cycle: `start_req` wins.
  - **Undefined:** the port is absent and there is no step logic.

## Test plan
- **Reset state:** assert `rst` for 2 cycles, then release. Required: `phase`=0, `p0`=1, `exec`=0, `halted`=0, `instr_count`=0.
- **Start/run:** raise `exec_btn` and hold it, with `SYNC_STAGES`=2 and `PHASES`=5.
  - `phase`=1 appears 4 edges after the rise.
  - The sequence is 1,2,3,4,5,1,...
  - `instr_done` pulses at every phase 5.
  - `instr_count`=3 after 15 running cycles.
- **HLT:** assert `stop_flag`=1 only at phase 5 of the 2nd instruction.
  - The next cycle has `phase`=0, `exec`=0, `halted`=1, `instr_count`=2.
  - Also assert `stop_flag`=1 at phase 3 of an instruction: required response is no effect.
- **Button stop:** pulse `exec_btn` during phase 2 of instruction N.
  - Instruction N completes through phase 5, then the sequencer goes to IDLE with `halted`=0.
  - A second press during STOPPING is ignored.
- **Reset mid-operation and wrap:**
  - `rst` at phase 3: the next cycle has `phase`=0 and `instr_count`=0.
  - Run from `instr_count`=0xFFFF: one retirement gives 0x0000.
- **Single step** (with SINGLE_STEP_EN): pulse `step_btn` in IDLE.
  - Exactly phases 1..5 run, then `phase`=0, with `instr_count` incremented by 1.
  - `step_btn` pulsed during RUN is ignored.
